// File: rtl/mem_arbiter.sv
// mem_arbiter -- single-port arbiter between the L1 caches and a one-word RAM.
//
// Data requests win over instruction fetches, except when the instruction side
// has watched STARVE_MAX data words complete while it was waiting. In that case
// the next grant goes to the fetch. Each grant moves exactly one word. Every
// grant re-arbitrates through IDLE.
//
// Optional build macro: MEM_ARB_STATS_EN adds the dacc_cnt, iacc_cnt and
// stall_cnt activity counters.
//
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-low reset
//   dREN, dWEN           data read / write request (a write wins if both are set)
//   daddr, dstore        data word address and write value
//   dwait, dload         data stall flag and read value
//   iREN, iaddr          instruction fetch request and address
//   iwait, iload         fetch stall flag and fetch value
//   ramREN, ramWEN       RAM read / write strobes
//   ramaddr, ramstore    RAM address and write data
//   ramload, ramstate    RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   dacc_cnt, iacc_cnt,  (MEM_ARB_STATS_EN only) completed data words,
//   stall_cnt             completed fetches, and grant cycles without ACCESS
module mem_arbiter #(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0]       dacc_cnt,
  output logic [31:0]       iacc_cnt,
  output logic [31:0]       stall_cnt,
`endif
  input  logic [1:0]        ramstate
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] DGNT = 2'b01;
  localparam logic [1:0] IGNT = 2'b10;

  localparam logic [1:0] RAM_ACCESS = 2'b10;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state, next_state;
  logic [3:0] starve_cnt, next_starve;
  logic       d_req;

  assign d_req = dREN | dWEN;

  // Every output is decoded from the registered state and the live inputs.
  always_comb begin
    next_state  = state;
    next_starve = starve_cnt;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    dwait       = 1'b1;
    iwait       = 1'b1;
    dload       = '0;
    iload       = '0;
    case (state)
      IDLE: begin
        if (iREN && (!d_req || starve_cnt == STARVE_LIM))
          next_state = IGNT;
        else if (d_req)
          next_state = DGNT;
      end
      DGNT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (!d_req) begin
          // The requester withdrew. The strobes are already low, so go back
          // to IDLE without completing the word.
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          dwait      = 1'b0;
          dload      = ramload;
          next_state = IDLE;
          if (iREN && starve_cnt < STARVE_LIM)
            next_starve = starve_cnt + 4'd1;
        end
        // FREE, BUSY and ERROR hold the grant and the strobes. This retries
        // an ERROR response.
      end
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          next_state = IDLE;
        end else if (ramstate == RAM_ACCESS) begin
          iwait       = 1'b0;
          iload       = ramload;
          next_starve = '0;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_starve;
    end
  end

`ifdef MEM_ARB_STATS_EN
  // A wait line is low only in the cycle its word completes. That makes it
  // the completion event to count.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      dacc_cnt  <= '0;
      iacc_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (!dwait)
        dacc_cnt <= dacc_cnt + 32'd1;
      if (!iwait)
        iacc_cnt <= iacc_cnt + 32'd1;
      if ((state == DGNT || state == IGNT) && ramstate != RAM_ACCESS)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port arbiter between the L1 caches and the one-word RAM.
- Downstream of the data cache and the instruction cache: consumes their dREN/dWEN/daddr/dstore and iREN/iaddr requests, drives the RAM port, and returns dwait/dload and iwait/iload.
- Data requests have priority.
- A bounded starvation counter guarantees instruction fetch progress.
- One word is transferred per grant.

Parameters:
- WORD_W, 32: data/address width.
- STARVE_MAX, 4: completed data accesses allowed while iREN is pending before the instruction side is forced a grant (range 1..15).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  synchronous active-low reset, sampled on the CLK rising edge.
- dREN  in  1  data read request from dcache.
- dWEN  in  1  data write request from dcache.
- daddr  in  WORD_W  data word address.
- dstore  in  WORD_W  data write value.
- dwait  out  1  high until the current data word completes.
- dload  out  WORD_W  data read value; valid when dREN=1 and dwait=0.
- iREN  in  1  instruction fetch request from icache.
- iaddr  in  WORD_W  fetch address.
- iwait  out  1  high until the fetch completes.
- iload  out  WORD_W  fetch value; valid when iwait=0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.

Behaviour:
- Reset (nRST low at a CLK edge):
  - state=IDLE, starve_cnt=0.
  - Outputs settle next cycle to: ramREN=ramWEN=0, ramaddr=ramstore=0, dwait=iwait=1, dload=iload=0.
- FSM states: IDLE, DGNT, IGNT. Transitions are registered.
- IDLE:
  - No RAM strobes are driven; dwait=iwait=1.
  - Next state:
    - IGNT if iREN && (!(dREN|dWEN) || starve_cnt==STARVE_MAX).
    - Else DGNT if dREN|dWEN.
    - Else IDLE.
- DGNT:
  - ramaddr=daddr and ramstore=dstore, combinational pass-through of the current requester values.
  - If dWEN=1: ramWEN=1, ramREN=0. A write wins when dREN and dWEN are both high.
  - Otherwise ramREN=dREN.
  - On ramstate==ACCESS, in the same cycle:
    - dwait=0 and dload=ramload.
    - Next state IDLE.
    - starve_cnt increments if iREN=1, saturating at STARVE_MAX.
  - FREE, BUSY or ERROR: dwait=1, hold DGNT. ERROR is retried by continuing to hold the strobes.
  - dREN=dWEN=0 while in DGNT (request withdrawn): drop the strobes that cycle; next state IDLE; no counter change.
- IGNT:
  - ramREN=1, ramaddr=iaddr, ramWEN=0.
  - On ACCESS: iwait=0, iload=ramload, starve_cnt cleared to 0, next state IDLE.
  - iREN withdrawn: next state IDLE.
  - iwait stays 1 whenever dwait is 0, and vice versa. Both are never low in the same cycle.
- Latency:
  - Minimum 2 cycles per word: the IDLE grant cycle plus the ACCESS cycle.
  - Back-to-back words from the same requester re-arbitrate through IDLE each time.
  - A 2-word block transfer therefore takes at least 4 cycles, plus RAM latency.
- Simultaneous requests:
  - dcache and icache both requesting with starve_cnt<STARVE_MAX: data is granted.
  - With starve_cnt==STARVE_MAX: instruction is granted.
- Reset mid-grant: the FSM returns to IDLE; the in-flight RAM access is abandoned and no wait line is released.
- Outputs are combinational from state plus inputs; no output is registered apart from the state.

Optional Feature:
- MEM_ARB_STATS_EN: when defined, adds three outputs.
  - dacc_cnt  out  32: completed data words.
  - iacc_cnt  out  32: completed fetch words.
  - stall_cnt  out  32: cycles in DGNT/IGNT with ramstate!=ACCESS.
  - All three reset to 0, wrap modulo 2^32, and update on the CLK edge after the counted event.
- Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
1. Reset then idle: nRST low for 2 cycles, then no requests for 5 cycles -> ramREN=ramWEN=0, dwait=iwait=1, state IDLE throughout.
2. Data read:
   - Stimulus: dREN=1, daddr=0x40; RAM returns BUSY for 2 cycles, then ACCESS with ramload=0xDEADBEEF.
   - Required: ramREN=1 and ramaddr=0x40 from cycle 2; dwait=0 and dload=0xDEADBEEF only in the ACCESS cycle; iwait stays 1.
3. Data write priority:
   - Stimulus: dWEN=1 and iREN=1 in the same cycle, daddr=0x3100, dstore=0x5.
   - Required: DGNT first with ramWEN=1, ramstore=0x5; after ACCESS, IDLE, then IGNT serves the fetch.
4. Starvation:
   - Stimulus: iREN held, dREN held continuously, every access completing immediately.
   - Required: exactly 4 data completions, then one instruction completion (iwait=0), then starve_cnt=0 and data resumes.
5. Withdraw and reset:
   - dREN dropped while DGNT and ramstate=BUSY -> strobes drop the same cycle and the FSM is IDLE next cycle.
   - nRST low during IGNT -> IDLE next cycle, iwait stays 1.
6. Stats (MEM_ARB_STATS_EN defined):
   - Stimulus: 3 data words and 2 fetches, each with one BUSY cycle.
   - Required: dacc_cnt=3, iacc_cnt=2, stall_cnt=5.
